// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory stream master: FSM states and word/lane geometry.
package mem_stream_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_L_COLLECT = 3'd1,
        S_L_WRITE   = 3'd2,
        S_D_READ    = 3'd3,
        S_D_SEND    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/mem_stream_master.sv
// Bus initiator: packs a byte stream into sequential word writes (load) and
// unpacks sequential word reads into a byte stream (dump), little-endian.
// Outputs are registered from the next-state decode, so every output is a flop.
module mem_stream_master
    import mem_stream_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    word_idx_q, word_idx_d;
    logic [LANE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   wbuf_q, wbuf_d;
    logic [ADDR_W-1:0]   addr_d;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wbuf_d     = wbuf_q;

        case (state_q)
            S_IDLE: begin
                if (start_load || start_dump) begin
                    base_d     = base_addr & ~ADDR_W'(3);
                    cnt_d      = word_count;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                    end else if (start_load) begin
                        state_d = S_L_COLLECT;
                    end else begin
                        state_d = S_D_READ;
                    end
                end
            end
            S_L_COLLECT: begin
                if (in_valid && in_ready) begin
                    wbuf_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + LANE_W'(1);
                    if (byte_idx_q == LAST_LANE) begin
                        state_d = S_L_WRITE;
                    end
                end
            end
            S_L_WRITE: begin
                word_idx_d = word_idx_q + CNT_W'(1);
                state_d    = (word_idx_d == cnt_q) ? S_DONE : S_L_COLLECT;
            end
            S_D_READ: begin
                shift_d = mem_rdata;
                state_d = S_D_SEND;
            end
            S_D_SEND: begin
                if (out_ready) begin
                    shift_d    = shift_q >> 8;
                    byte_idx_d = byte_idx_q + LANE_W'(1);
                    if (byte_idx_q == LAST_LANE) begin
                        word_idx_d = word_idx_q + CNT_W'(1);
                        state_d    = (word_idx_d == cnt_q) ? S_DONE : S_D_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end

        addr_d = base_d + (ADDR_W'(word_idx_d) << 2);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            wbuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            wbuf_q     <= wbuf_d;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_ready  <= (state_d == S_L_COLLECT);
            out_valid <= (state_d == S_D_SEND);
            out_data  <= (state_d == S_D_SEND) ? shift_d[7:0] : 8'h00;
            mem_rd    <= (state_d == S_D_READ);
            mem_wr    <= (state_d == S_L_WRITE);
            mem_addr  <= (state_d == S_D_READ || state_d == S_L_WRITE) ? addr_d : '0;
            mem_wdata <= (state_d == S_L_WRITE) ? wbuf_d : '0;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_mem_stream_master.sv
// Randomized self-checking bench for mem_stream_master with a word-level reference model.
module tb_mem_stream_master;

    logic        clk;
    logic        reset;
    logic        start_load;
    logic        start_dump;
    logic        abort;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    mem_stream_master #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_load (start_load),
        .start_dump (start_dump),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small backing memory, aliased on address bits [9:2].
    logic [31:0] mem [0:255];
    assign mem_rdata = mem_rd ? mem[mem_addr[9:2]] : 32'h0;

    int          checks;
    int          failures;
    logic [7:0]  in_q[$];
    logic [7:0]  out_q[$];
    logic [63:0] wr_q[$];
    int          done_cnt;
    int          rd_cnt;
    int          valid_pct;
    int          ready_mode;
    bit          tog;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, record the handshakes/writes at the edge, sample at negedge.
    task automatic cycle();
        logic       hs_in;
        logic       hs_out;
        logic       hold;
        logic [7:0] od;
        in_valid = (in_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
        in_data  = (in_q.size() > 0) ? in_q[0] : 8'h00;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = tog; tog = !tog; end
            2:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
        hs_in  = in_valid && in_ready;
        hs_out = out_valid && out_ready;
        hold   = out_valid && !out_ready;
        od     = out_data;
        if (mem_rd && mem_wr) check("rd_wr_exclusive", 1, 0);
        if (!mem_wr) check("wdata_zero_when_idle", mem_wdata, 0);
        if (mem_wr) begin
            wr_q.push_back({mem_addr, mem_wdata});
            mem[mem_addr[9:2]] = mem_wdata;
        end
        if (mem_rd) rd_cnt++;
        @(posedge clk);
        @(negedge clk);
        if (hs_in) void'(in_q.pop_front());
        if (hs_out) out_q.push_back(od);
        if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, od);
        end
        if (done) done_cnt++;
    endtask

    // Run one load or dump and compare against the word-level model.
    task automatic run_xfer(input bit load, input bit both, input logic [31:0] base, input int n,
                            input int vpct, input int rmode, input bit timed, input bit fixed);
        logic [31:0] b;
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  x;
        logic [63:0] exp_w[$];
        logic [7:0]  exp_b[$];
        int          d0;
        int          r0;
        int          calls;
        int          done_at;
        b       = base & 32'hFFFF_FFFC;
        d0      = done_cnt;
        r0      = rd_cnt;
        done_at = -1;
        wr_q.delete();
        out_q.delete();
        in_q.delete();
        for (int i = 0; i < n; i++) begin
            a = b + 32'(4 * i);
            if (load) begin
                w = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    x = fixed ? 8'(8'h11 * (4 * i + k + 1)) : 8'($urandom);
                    in_q.push_back(x);
                    w[8*k +: 8] = x;
                end
                exp_w.push_back({a, w});
            end else begin
                w = mem[a[9:2]];
                for (int k = 0; k < 4; k++) exp_b.push_back(w[8*k +: 8]);
            end
        end
        valid_pct  = vpct;
        ready_mode = rmode;
        base_addr  = base;
        word_count = 16'(n);
        start_load = load;
        start_dump = !load || both;
        cycle();
        start_load = 1'b0;
        start_dump = 1'b0;
        calls = 1;
        if (done_cnt != d0) done_at = 1;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, load && n != 0);
        check("mem_rd_after_start", mem_rd, !load && n != 0);
        while (done_cnt == d0 && calls < 3000) begin
            cycle();
            calls++;
            if (done_cnt != d0 && done_at < 0) done_at = calls;
        end
        check("timeout", done_cnt == d0, 0);
        cycle();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("done_count", done_cnt - d0, 1);
        if (timed) check("latency", done_at, 5 * n + 1);
        if (load) begin
            check("wr_count", wr_q.size(), n);
            check("rd_during_load", rd_cnt - r0, 0);
            check("bytes_consumed", in_q.size(), 0);
            for (int i = 0; i < n && i < wr_q.size(); i++) check("write_addr_data", wr_q[i], exp_w[i]);
        end else begin
            check("rd_count", rd_cnt - r0, n);
            check("wr_during_dump", wr_q.size(), 0);
            check("byte_count", out_q.size(), 4 * n);
            for (int i = 0; i < 4 * n && i < out_q.size(); i++) check("dump_byte", out_q[i], exp_b[i]);
        end
    endtask

    initial begin
        int d0;
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        rd_cnt     = 0;
        valid_pct  = 100;
        ready_mode = 0;
        tog        = 1'b0;
        reset      = 1'b0;
        start_load = 1'b0;
        start_dump = 1'b0;
        abort      = 1'b0;
        base_addr  = 32'h0;
        word_count = 16'h0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {in_ready, out_valid, out_data, mem_rd, mem_wr, mem_addr, mem_wdata, busy, done}, 0);
        reset = 1'b1;
        cycle();
        check("idle_after_reset", busy, 0);

        // Fixed load of 11..88 at 0x10, then dump with a toggling ready.
        run_xfer(1, 0, 32'h10, 2, 100, 0, 1, 1);
        check("word0_value", mem[4], 32'h4433_2211);
        check("word1_value", mem[5], 32'h8877_6655);
        run_xfer(0, 0, 32'h10, 2, 100, 1, 0, 0);

        // Zero-length dump.
        run_xfer(0, 0, 32'h40, 0, 100, 0, 1, 0);

        // Simultaneous starts: load wins.
        run_xfer(1, 1, 32'h80, 1, 100, 0, 1, 0);

        // Abort after three bytes of a word.
        wr_q.delete();
        in_q.delete();
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) in_q.push_back(8'($urandom));
        valid_pct  = 100;
        base_addr  = 32'h40;
        word_count = 16'd1;
        start_load = 1'b1;
        cycle();
        start_load = 1'b0;
        repeat (3) cycle();
        check("abort_bytes_taken", in_q.size(), 0);
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_in_ready", in_ready, 0);
        repeat (6) cycle();
        check("abort_no_write", wr_q.size(), 0);
        check("abort_no_done", done_cnt - d0, 0);

        // Wrapping address and unaligned base.
        run_xfer(1, 0, 32'hFFFF_FFFC, 2, 100, 0, 1, 0);
        run_xfer(0, 0, 32'hFFFF_FFFC, 2, 100, 2, 0, 0);
        run_xfer(1, 0, 32'h13, 1, 100, 0, 1, 0);

        // Asynchronous reset while holding a byte in D_SEND.
        run_xfer(1, 0, 32'h20, 2, 100, 0, 1, 0);
        ready_mode = 3;
        base_addr  = 32'h20;
        word_count = 16'd2;
        start_dump = 1'b1;
        cycle();
        start_dump = 1'b0;
        cycle();
        check("send_valid_before_reset", out_valid, 1);
        check("send_byte_before_reset", out_data, mem[8] & 32'hFF);
        #2 reset = 1'b0;
        #1 check("reset_mid_dump",
                 {in_ready, out_valid, out_data, mem_rd, mem_wr, mem_addr, mem_wdata, busy, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        check("idle_after_mid_reset", busy, 0);

        // Random load/dump pairs over random regions.
        for (int t = 0; t < 30; t++) begin
            logic [31:0] rb;
            int          n;
            int          vp;
            int          rm;
            rb = $urandom;
            n  = $urandom_range(1, 5);
            vp = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(30, 90);
            rm = ($urandom_range(0, 1) == 1) ? 0 : 2;
            run_xfer(1, 0, rb, n, vp, 0, vp == 100, 0);
            run_xfer(0, 0, rb, n, 100, rm, rm == 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
